// File: rtl/decode_stage_pkg.sv
// Package common: opcode map, decoded-record layout and the FIFO fill-level type
// shared by the decode stage, its interface and the immediate generator.
package common;

  // Widest supported XLEN. Record pc/imm fields are this wide; a 32-bit build
  // leaves bits [63:32] at zero so both builds share one record type.
  localparam int XLEN_MAX = 64;

  // Base opcodes (instr[6:0]) recognised by the decoder
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_MADD     = 7'b1000011;
  localparam logic [6:0] OPC_MSUB     = 7'b1000111;
  localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
  localparam logic [6:0] OPC_NMADD    = 7'b1001111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Instruction format class; R_TYPE encodes as 0 so a cleared record reads as all zeros
  typedef enum logic [2:0] {
    R_TYPE,
    I_TYPE,
    S_TYPE,
    B_TYPE,
    U_TYPE,
    J_TYPE,
    SYS_TYPE,
    ILLEGAL_TYPE
  } instruction_op_type;

  // Record handed to execute
  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [6:0]          opcode;
    instruction_op_type  optype;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [XLEN_MAX-1:0] imm;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                illegal;
  } decoded_instr_t;

  // Occupancy of the two-entry output FIFO
  typedef enum logic [1:0] {
    FILL_EMPTY,
    FILL_ONE,
    FILL_FULL
  } fill_state_t;

  // Opcode -> format class; unknown opcodes fall into ILLEGAL_TYPE
  function automatic instruction_op_type opcode_to_optype(input logic [6:0] opc);
    instruction_op_type t;
    case (opc)
      OPC_OP, OPC_OP_FP, OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: t = R_TYPE;
      OPC_OP_IMM, OPC_JALR, OPC_LOAD, OPC_LOAD_FP:                 t = I_TYPE;
      OPC_STORE, OPC_STORE_FP:                                     t = S_TYPE;
      OPC_BRANCH:                                                  t = B_TYPE;
      OPC_LUI, OPC_AUIPC:                                          t = U_TYPE;
      OPC_JAL:                                                     t = J_TYPE;
      OPC_SYSTEM:                                                  t = SYS_TYPE;
      default:                                                     t = ILLEGAL_TYPE;
    endcase
    return t;
  endfunction

  // Register-file write enable; x0 writes are suppressed, SYSTEM only writes
  // for CSR forms (funct3 != 0), never for ECALL/EBREAK/xRET
  function automatic logic writes_rd(input instruction_op_type t,
                                     input logic [2:0] f3,
                                     input logic [4:0] rd);
    logic wr;
    wr = 1'b0;
    if (rd != 5'd0) begin
      case (t)
        R_TYPE, I_TYPE, U_TYPE, J_TYPE: wr = 1'b1;
        SYS_TYPE:                       wr = (f3 != 3'd0);
        default:                        wr = 1'b0;
      endcase
    end
    return wr;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshakes of the decode stage, plus flush.
// master = the pipeline around the stage, slave = the decode stage itself.
interface decode_stage_if #(
  parameter int XLEN = 32
) ();
  import common::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  decoded_instr_t  out_dec;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_dec
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_dec
  );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: purely combinational immediate extraction. The immediate is built
// as 32 bits then sign-extended from instr[31] to XLEN.
module imm_gen
  import common::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]        i_instr,
  input  instruction_op_type i_optype,
  output logic [XLEN-1:0]    o_imm
);

  logic [31:0] w_imm32;

  // Select the immediate layout of the instruction's format; other classes yield 0
  always_comb begin
    w_imm32 = '0;
    case (i_optype)
      I_TYPE: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      S_TYPE: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      B_TYPE: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
      U_TYPE: w_imm32 = {i_instr[31:12], 12'b0};
      J_TYPE: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes one RV32/RV64 instruction per accepted handshake and
// queues the record in a two-entry FIFO. Decode happens before the FIFO, so
// a record is visible on out_dec the cycle after it is accepted.
module decode_stage
  import common::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);

  // ---------------------------------------------------------------- decode
  instruction_op_type w_optype;
  logic               w_illegal;
  logic [XLEN-1:0]    w_imm;
  decoded_instr_t     w_dec;

  // Classify the word; anything not ending in 2'b11 is not a 32-bit encoding
  always_comb begin
    w_optype = opcode_to_optype(bus.in_instr[6:0]);
    if (bus.in_instr[1:0] != 2'b11) begin
      w_optype = ILLEGAL_TYPE;
    end
  end

  assign w_illegal = (w_optype == ILLEGAL_TYPE);

  // ILLEGAL_TYPE selects the zero immediate inside imm_gen
  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .i_instr  (bus.in_instr[31:7]),
    .i_optype (w_optype),
    .o_imm    (w_imm)
  );

  // Assemble the record; side-effect flags are forced off for illegal words
  always_comb begin
    w_dec           = '0;
    w_dec.pc        = XLEN_MAX'(bus.in_pc);
    w_dec.opcode    = bus.in_instr[6:0];
    w_dec.optype    = w_optype;
    w_dec.rd        = bus.in_instr[11:7];
    w_dec.rs1       = bus.in_instr[19:15];
    w_dec.rs2       = bus.in_instr[24:20];
    w_dec.funct3    = bus.in_instr[14:12];
    w_dec.funct7    = bus.in_instr[31:25];
    w_dec.imm       = XLEN_MAX'(w_imm);
    w_dec.illegal   = w_illegal;
    if (!w_illegal) begin
      w_dec.mem_read  = (bus.in_instr[6:0] == OPC_LOAD) ||
                        (bus.in_instr[6:0] == OPC_LOAD_FP);
      w_dec.mem_write = (bus.in_instr[6:0] == OPC_STORE) ||
                        (bus.in_instr[6:0] == OPC_STORE_FP);
      w_dec.reg_write = writes_rd(w_optype, bus.in_instr[14:12], bus.in_instr[11:7]);
    end
  end

  // ------------------------------------------------------- occupancy FSM
  fill_state_t r_state;
  fill_state_t w_state_next;
  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_push;
  logic        w_pop;

  // Hold the fill level; reset wins over flush and both empty the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Handshake outputs depend on the fill level only; next level from push/pop/flush
  always_comb begin
    w_in_ready   = (r_state != FILL_FULL);
    w_out_valid  = (r_state != FILL_EMPTY);
    w_push       = bus.in_valid && w_in_ready && !bus.flush;
    w_pop        = w_out_valid && bus.out_ready;
    w_state_next = r_state;
    if (bus.flush) begin
      w_state_next = FILL_EMPTY;
    end else begin
      case (r_state)
        FILL_EMPTY: if (w_push) w_state_next = FILL_ONE;
        FILL_ONE: begin
          if (w_push && !w_pop) w_state_next = FILL_FULL;
          else if (w_pop && !w_push) w_state_next = FILL_EMPTY;
        end
        FILL_FULL: if (w_pop) w_state_next = FILL_ONE;
        default: w_state_next = FILL_EMPTY;
      endcase
    end
  end

  // ------------------------------------------------------------- storage
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  decoded_instr_t [1:0]  w_slot;

  // Ring pointers; a flush realigns both to slot 0 together with the fill level
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    decoded_instr_t r_entry;

    // Capture the decoded record when this slot is the write target; slots
    // are never cleared because an empty FIFO masks them at the output
    always_ff @(posedge clk) begin
      if (w_push && (int'(r_wr_ptr) == gi)) begin
        r_entry <= w_dec;
      end
    end

    assign w_slot[gi] = r_entry;
  end

  // ------------------------------------------------------------- outputs
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_dec   = w_out_valid ? w_slot[r_rd_ptr] : '0;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: an XLEN=32 and an XLEN=64 instance share stimulus.
// A queue of accepted (instr, pc) pairs models the FIFO; expected records are
// computed from the instruction-format rules with plain integer arithmetic.
`timescale 1ns/1ps
module tb_decode_stage;
  import common::*;

  logic clk;
  logic rst;

  decode_stage_if #(.XLEN(32)) b32 ();
  decode_stage_if #(.XLEN(64)) b64 ();

  decode_stage #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  decode_stage #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
  } txn_t;

  txn_t       mq[$];
  logic [4:0] seen_rd[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [6:0] opc_tab [0:20];

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference decode from the format rules
  function automatic decoded_instr_t ref_decode(input logic [31:0] ins, input logic [63:0] pc,
                                                input int xlen);
    decoded_instr_t d;
    longint         s;
    logic [63:0]    imm;
    d = '0;
    s = longint'($signed(ins));
    d.pc     = (xlen == 32) ? {32'h0, pc[31:0]} : pc;
    d.opcode = ins[6:0];
    d.rd     = ins[11:7];
    d.rs1    = ins[19:15];
    d.rs2    = ins[24:20];
    d.funct3 = ins[14:12];
    d.funct7 = ins[31:25];
    case (ins[6:0])
      7'h33, 7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F: d.optype = R_TYPE;
      7'h13, 7'h67, 7'h03, 7'h07:               d.optype = I_TYPE;
      7'h23, 7'h27:                             d.optype = S_TYPE;
      7'h63:                                    d.optype = B_TYPE;
      7'h37, 7'h17:                             d.optype = U_TYPE;
      7'h6F:                                    d.optype = J_TYPE;
      7'h73:                                    d.optype = SYS_TYPE;
      default:                                  d.optype = ILLEGAL_TYPE;
    endcase
    if (ins[1:0] != 2'b11) d.optype = ILLEGAL_TYPE;
    case (d.optype)
      I_TYPE: imm = 64'(s >>> 20);
      S_TYPE: imm = 64'((s >>> 20) & ~longint'(31)) | 64'(ins[11:7]);
      B_TYPE: imm = 64'((s >>> 31) << 12) | (64'(ins[7]) << 11) |
                    (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
      U_TYPE: imm = 64'((s >>> 12) << 12);
      J_TYPE: imm = 64'((s >>> 31) << 20) | (64'(ins[19:12]) << 12) |
                    (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
      default: imm = 64'd0;
    endcase
    if (xlen == 32) imm[63:32] = 32'd0;
    d.imm       = imm;
    d.mem_read  = (ins[6:0] == 7'h03) || (ins[6:0] == 7'h07);
    d.mem_write = (ins[6:0] == 7'h23) || (ins[6:0] == 7'h27);
    d.reg_write = (ins[11:7] != 5'd0) &&
                  ((d.optype inside {R_TYPE, I_TYPE, U_TYPE, J_TYPE}) ||
                   (d.optype == SYS_TYPE && ins[14:12] != 3'd0));
    d.illegal   = (d.optype == ILLEGAL_TYPE);
    return d;
  endfunction

  task automatic compare_outputs();
    check_val("rdy32", b32.in_ready,  mq.size() < 2);
    check_val("vld32", b32.out_valid, mq.size() > 0);
    check_val("rdy64", b64.in_ready,  mq.size() < 2);
    check_val("vld64", b64.out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      check_val("dec32", b32.out_dec, ref_decode(mq[0].ins, mq[0].pc, 32));
      check_val("dec64", b64.out_dec, ref_decode(mq[0].ins, mq[0].pc, 64));
    end
  endtask

  // Drive one cycle, advance the model, then check #1 after the edge
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic fl, input logic ordy, input logic rs);
    int   sz;
    logic push;
    logic pop;
    txn_t t;
    b32.in_valid = v;  b32.in_instr = ins; b32.in_pc = pc[31:0];
    b32.flush = fl;    b32.out_ready = ordy;
    b64.in_valid = v;  b64.in_instr = ins; b64.in_pc = pc;
    b64.flush = fl;    b64.out_ready = ordy;
    rst = rs;
    if (b64.out_valid && ordy && !rs) seen_rd.push_back(b64.out_dec.rd);
    sz = mq.size();
    if (rs || fl) begin
      mq.delete();
    end else begin
      push = v && (sz < 2);
      pop  = (sz > 0) && ordy;
      if (pop) begin
        $display("xfer instr=%h pc=%h", mq[0].ins, mq[0].pc);
        void'(mq.pop_front());
      end
      if (push) begin
        t.ins = ins;
        t.pc  = pc;
        mq.push_back(t);
      end
    end
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  initial begin
    logic [31:0] ins;
    logic [63:0] pc;
    opc_tab = '{7'h03, 7'h07, 7'h13, 7'h17, 7'h23, 7'h27, 7'h33, 7'h37, 7'h43, 7'h47, 7'h4B,
                7'h4F, 7'h53, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h0F, 7'h1B, 7'h3B, 7'h7F};
    rst = 1'b1;

    // reset state
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b0);
    check_val("rst_vld", b32.out_valid, 1'b0);
    check_val("rst_rdy", b64.in_ready, 1'b1);
    check_val("rst_dec", b64.out_dec, 256'd0);

    // addi x1,x0,-1
    step(1'b1, 32'hFFF00093, 64'h1000, 1'b0, 1'b1, 1'b0);
    check_val("addi_type", b32.out_dec.optype, I_TYPE);
    check_val("addi_rd",   b64.out_dec.rd, 5'd1);
    check_val("addi_imm32", b32.out_dec.imm, 64'h0000_0000_FFFF_FFFF);
    check_val("addi_imm64", b64.out_dec.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("addi_wr",   {b32.out_dec.reg_write, b64.out_dec.reg_write}, 2'b11);
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b0);

    // sw then beq back to back
    step(1'b1, 32'h0020A423, 64'h1004, 1'b0, 1'b1, 1'b0);
    check_val("sw_type",  b32.out_dec.optype, S_TYPE);
    check_val("sw_imm",   b32.out_dec.imm, 64'd8);
    check_val("sw_flags", {b64.out_dec.mem_write, b64.out_dec.reg_write}, 2'b10);
    step(1'b1, 32'hFE000EE3, 64'h1008, 1'b0, 1'b1, 1'b0);
    check_val("beq_type",  b64.out_dec.optype, B_TYPE);
    check_val("beq_imm32", b32.out_dec.imm, 64'h0000_0000_FFFF_FFFC);
    check_val("beq_imm64", b64.out_dec.imm, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b0);

    // lui x5,0x12345
    step(1'b1, 32'h123452B7, 64'h100C, 1'b0, 1'b1, 1'b0);
    check_val("lui_type", b32.out_dec.optype, U_TYPE);
    check_val("lui_imm",  b64.out_dec.imm, 64'h1234_5000);
    check_val("lui_rd",   b32.out_dec.rd, 5'd5);
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b0);

    // back-pressure: three offered, two taken, then all three in order
    seen_rd.delete();
    step(1'b1, 32'h00000193, 64'h2000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00000213, 64'h2004, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00000313, 64'h2008, 1'b0, 1'b0, 1'b0);
    check_val("full_rdy", b64.in_ready, 1'b0);
    check_val("hold_rd",  b32.out_dec.rd, 5'd3);
    step(1'b1, 32'h00000313, 64'h2008, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h00000313, 64'h2008, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b0);
    check_val("order_cnt", seen_rd.size(), 3);
    if (seen_rd.size() == 3)
      check_val("order_rd", {seen_rd[0], seen_rd[1], seen_rd[2]}, {5'd3, 5'd4, 5'd6});

    // flush with two held and a concurrent offer
    step(1'b1, 32'h00000393, 64'h3000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00000413, 64'h3004, 1'b0, 1'b0, 1'b0);
    seen_rd.delete();
    step(1'b1, 32'h00000493, 64'h3008, 1'b1, 1'b0, 1'b0);
    check_val("flush_vld", b32.out_valid, 1'b0);
    check_val("flush_rdy", b64.in_ready, 1'b1);
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b0);
    check_val("flush_gone", seen_rd.size(), 0);

    // illegal word, then reset with it held
    step(1'b1, 32'h0000007F, 64'h4000, 1'b0, 1'b0, 1'b0);
    check_val("ill_flags32", {b32.out_dec.illegal, b32.out_dec.mem_read,
                              b32.out_dec.mem_write, b32.out_dec.reg_write}, 4'b1000);
    check_val("ill_flags64", {b64.out_dec.illegal, b64.out_dec.mem_read,
                              b64.out_dec.mem_write, b64.out_dec.reg_write}, 4'b1000);
    check_val("ill_type", b64.out_dec.optype, ILLEGAL_TYPE);
    check_val("ill_imm",  b64.out_dec.imm, 64'd0);
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b0);
    check_val("rst2_vld",   b64.out_valid, 1'b0);
    check_val("rst2_dec32", b32.out_dec, 256'd0);
    check_val("rst2_dec64", b64.out_dec, 256'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ins = $urandom();
      if ($urandom_range(0, 7) != 0) ins[6:0] = opc_tab[$urandom_range(0, 20)];
      pc = {$urandom(), $urandom()};
      step($urandom_range(0, 3) != 0, ins, pc, $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
